reverb_comb_inverse: RTL and testbench
======================================

// Module: reverb_comb_inverse
// PURPOSE
//  Inverse (de-reverberation) comb filter: removes the echo a feedback comb with gain 1/2^FB_SHIFT
//  and delay D adds. Inverts exactly, including 16-bit wraparound:
//  Out[n] = In[n] - (In[n-D] >> FB_SHIFT) mod 2^DATA_W.
//  Sits in the single-clock audio path after a reverberated stream and before the DAC/analysis stage.
//  Holds its own circular delay line of past inputs. Stream in/out uses a valid/ready handshake.
// PARAMETERS
//  DATA_W   16  sample width (unsigned, modular arithmetic, as produced by the reverb path)
//  ADDR_W   10  delay-line address width; depth 2^ADDR_W entries, max D = 2^ADDR_W-1
//  FB_SHIFT 1   feedback attenuation shift; must match the reverb being inverted
// PORTS
//  Clk        in   1       system clock, all logic on rising edge
//  rst        in   1       asynchronous, active-high reset
//  Flush      in   1       sync clear: empty delay line, relatch Delay_Num, return to FILL
//  Delay_Num  in   ADDR_W  echo delay D in samples; latched only at reset release / Flush
//  In_Valid   in   1       input sample valid
//  In_Ready   out  1       block can accept a sample this cycle
//  In_Data    in   DATA_W  reverberated input sample
//  Out_Valid  out  1       Out_Data holds a valid de-reverberated sample
//  Out_Ready  in   1       downstream accepts Out_Data this cycle
//  Out_Data   out  DATA_W  de-reverberated sample
//  Primed     out  1       delay line holds D samples; echo subtraction active
// BEHAVIOUR
//  Reset: Out_Valid=0, Out_Data=0, Primed=0, wr_ptr=0, fill_cnt=0, d_lat=0, state=LATCH.
//  Delay-line RAM contents are not reset.
//  States:
//   LATCH: one cycle after reset release or Flush. d_lat<=Delay_Num, In_Ready=0.
//          Next state is BYPASS if Delay_Num==0, else FILL.
//   BYPASS: Out=In. No RAM writes. Primed=0.
//   FILL: each accepted sample is written at wr_ptr and Out=In (no echo yet). fill_cnt++.
//         When fill_cnt reaches d_lat-1 on an accept, go to RUN.
//   RUN: read RAM[wr_ptr] (the sample from D accepts earlier), then write In at wr_ptr,
//        same cycle, read-before-write. Out = In - (rd >> FB_SHIFT), DATA_W bits, logical shift.
//        Primed=1.
//  wr_ptr wraps to 0 after d_lat-1; in FILL and RUN it advances only on accept.
//  Handshake:
//   - accept = In_Valid & In_Ready.
//   - In_Ready = (state!=LATCH) & (~Out_Valid | Out_Ready). Full throughput, no bubble.
//   - Output register: on accept, Out_Data/Out_Valid load next cycle (latency 1).
//   - If Out_Valid & ~Out_Ready, Out_Data is held stable and no input is accepted.
//   - Out_Valid clears on Out_Ready without a new accept.
//  Flush:
//   - Priority over accept in the same cycle: the sample is dropped.
//   - Out_Valid<=0, fill_cnt<=0, wr_ptr<=0, state<=LATCH.
//  Delay_Num changes outside LATCH are ignored.
//  Async rst mid-stream: immediate return to reset values. The pending output is lost.
//  D = 2^ADDR_W-1 is legal. The RAM index never reaches d_lat.
// TESTING
//  1 Reset, Delay_Num=4, FB_SHIFT=1, feed x: 100,0,0,0,200,0,0,0,0
//    -> out 100,0,0,0,150,0,0,0,65436 (0-100 wrap); Primed rises after the 4th accept.
//  2 Chain the existing reverb (D=4) into this block with random 16-bit x
//    -> Out==x bit-exact for all samples after priming, including wrap cases.
//  3 Out_Ready held low for 5 cycles mid-stream
//    -> In_Ready=0, Out_Data stable, no samples lost or duplicated after release.
//  4 Delay_Num=0 -> pure passthrough, Primed stays 0, latency 1.
//  5 Flush asserted with In_Valid=1 in RUN, Delay_Num changed 4->7
//    -> sample dropped, Out_Valid=0 next cycle, 7-sample FILL before subtraction resumes.
//  6 Delay_Num=1023 with a 3000-sample ramp
//    -> pointer wraps correctly; Out[n]=In[n]-(In[n-1023]>>1).

Source files
------------

// File: rtl/reverb_comb_inverse.sv
// Inverse feedback-comb filter: strips the 1/2^FB_SHIFT echo at delay D
// from a reverberated stream, bit-exact in modular DATA_W arithmetic.
module reverb_comb_inverse #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 10,
    parameter int FB_SHIFT = 1
) (
    input  logic              Clk,
    input  logic              rst,
    input  logic              Flush,
    input  logic [ADDR_W-1:0] Delay_Num,
    input  logic              In_Valid,
    output logic              In_Ready,
    input  logic [DATA_W-1:0] In_Data,
    output logic              Out_Valid,
    input  logic              Out_Ready,
    output logic [DATA_W-1:0] Out_Data,
    output logic              Primed
);

    localparam logic [1:0] ST_LATCH  = 2'd0;
    localparam logic [1:0] ST_BYPASS = 2'd1;
    localparam logic [1:0] ST_FILL   = 2'd2;
    localparam logic [1:0] ST_RUN    = 2'd3;

    localparam logic [ADDR_W-1:0] A_ZERO = '0;
    localparam logic [ADDR_W-1:0] A_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] d_lat_q, d_lat_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] fill_cnt_q, fill_cnt_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;

    logic [DATA_W-1:0] mem [2**ADDR_W];

    logic              in_ready;
    logic              accept;
    logic              mem_we;
    logic              ptr_last;
    logic [ADDR_W-1:0] d_last;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] echo;
    logic [DATA_W-1:0] diff;

    assign in_ready = (state_q != ST_LATCH) & (~out_valid_q | Out_Ready);
    assign accept   = In_Valid & in_ready;
    assign d_last   = d_lat_q - A_ONE;
    assign ptr_last = (wr_ptr_q == d_last);

    // Combinational read sees the old word; the write lands at the edge.
    assign rd_data = mem[wr_ptr_q];
    assign echo    = rd_data >> FB_SHIFT;
    assign diff    = In_Data - echo;

    assign mem_we = accept & ~Flush &
                    ((state_q == ST_FILL) | (state_q == ST_RUN));

    always_comb begin
        state_d     = state_q;
        d_lat_d     = d_lat_q;
        wr_ptr_d    = wr_ptr_q;
        fill_cnt_d  = fill_cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        if (Flush) begin
            state_d     = ST_LATCH;
            out_valid_d = 1'b0;
            fill_cnt_d  = A_ZERO;
            wr_ptr_d    = A_ZERO;
        end else begin
            if (Out_Ready) begin
                out_valid_d = 1'b0;
            end

            case (state_q)
                ST_LATCH: begin
                    d_lat_d = Delay_Num;
                    state_d = (Delay_Num == A_ZERO) ? ST_BYPASS : ST_FILL;
                end
                ST_BYPASS: begin
                    if (accept) begin
                        out_valid_d = 1'b1;
                        out_data_d  = In_Data;
                    end
                end
                ST_FILL: begin
                    if (accept) begin
                        out_valid_d = 1'b1;
                        out_data_d  = In_Data;
                        wr_ptr_d    = ptr_last ? A_ZERO : wr_ptr_q + A_ONE;
                        fill_cnt_d  = fill_cnt_q + A_ONE;
                        if (fill_cnt_q == d_last) begin
                            state_d = ST_RUN;
                        end
                    end
                end
                default: begin
                    if (accept) begin
                        out_valid_d = 1'b1;
                        out_data_d  = diff;
                        wr_ptr_d    = ptr_last ? A_ZERO : wr_ptr_q + A_ONE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge Clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_LATCH;
            d_lat_q     <= A_ZERO;
            wr_ptr_q    <= A_ZERO;
            fill_cnt_q  <= A_ZERO;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            d_lat_q     <= d_lat_d;
            wr_ptr_q    <= wr_ptr_d;
            fill_cnt_q  <= fill_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    // Delay-line storage is deliberately left unreset.
    always_ff @(posedge Clk) begin
        if (mem_we) begin
            mem[wr_ptr_q] <= In_Data;
        end
    end

    assign In_Ready  = in_ready;
    assign Out_Valid = out_valid_q;
    assign Out_Data  = out_data_q;
    assign Primed    = (state_q == ST_RUN);

endmodule

// File: tb/tb_reverb_comb_inverse.sv
// Bench for reverb_comb_inverse: vector table, forward-reverb chain,
// stalls, bypass, flush and long-delay wrap, checked through a scoreboard.
module tb_reverb_comb_inverse;

    localparam int DW = 16;
    localparam int AW = 10;

    logic          Clk = 1'b0;
    logic          rst = 1'b1;
    logic          Flush = 1'b0;
    logic [AW-1:0] Delay_Num = 10'd4;
    logic          In_Valid = 1'b0;
    logic          In_Ready;
    logic [DW-1:0] In_Data = '0;
    logic          Out_Valid;
    logic          Out_Ready = 1'b1;
    logic [DW-1:0] Out_Data;
    logic          Primed;

    reverb_comb_inverse #(.DATA_W(DW), .ADDR_W(AW), .FB_SHIFT(1)) dut (
        .Clk(Clk), .rst(rst), .Flush(Flush), .Delay_Num(Delay_Num),
        .In_Valid(In_Valid), .In_Ready(In_Ready), .In_Data(In_Data),
        .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
        .Out_Data(Out_Data), .Primed(Primed)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [DW-1:0] x;
        logic [DW-1:0] exp;
    } vec_t;

    int            errs = 0;
    int            checks = 0;
    logic [DW-1:0] sb[$];
    logic [DW-1:0] hist[$];
    int            dlat = 4;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge Clk) begin
        if (!rst && Out_Valid && Out_Ready) begin
            if (sb.size() == 0) begin
                checks++;
                errs++;
                $display("FAIL unexpected_out: got %0d expected none at %0t",
                         Out_Data, $time);
            end else begin
                chk("out_data", Out_Data, sb.pop_front());
            end
        end
    end

    function automatic logic [DW-1:0] model(logic [DW-1:0] x);
        int n = hist.size();
        logic [DW-1:0] e = x;
        if (dlat > 0 && n >= dlat) e = x - (hist[n-dlat] >> 1);
        hist.push_back(x);
        return e;
    endfunction

    task automatic send(logic [DW-1:0] x, logic [DW-1:0] e);
        int t = 0;
        In_Valid = 1'b1;
        In_Data  = x;
        @(negedge Clk);
        while (!In_Ready && t < 100) begin
            t++;
            @(negedge Clk);
        end
        if (!In_Ready) begin
            checks++;
            errs++;
            $display("FAIL send_timeout: got ready=0 required ready=1 at %0t", $time);
            In_Valid = 1'b0;
            return;
        end
        sb.push_back(e);
        @(posedge Clk);
        #1;
        In_Valid = 1'b0;
    endtask

    task automatic sendm(logic [DW-1:0] x);
        logic [DW-1:0] e;
        e = model(x);
        send(x, e);
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(negedge Clk);
            t++;
        end
        @(posedge Clk);
        #1;
        chk("drain_empty", sb.size(), 0);
    endtask

    task automatic do_flush(logic [AW-1:0] d);
        Delay_Num = d;
        Flush     = 1'b1;
        @(posedge Clk);
        #1;
        Flush = 1'b0;
        hist.delete();
        dlat = int'(d);
        chk("latch_not_ready", In_Ready, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t          tv[9];
        logic [DW-1:0] yh[$];
        logic [DW-1:0] x;
        logic [DW-1:0] y;
        logic [DW-1:0] held;

        tv[0] = '{16'd100, 16'd100};
        tv[1] = '{16'd0,   16'd0};
        tv[2] = '{16'd0,   16'd0};
        tv[3] = '{16'd0,   16'd0};
        tv[4] = '{16'd200, 16'd150};
        tv[5] = '{16'd0,   16'd0};
        tv[6] = '{16'd0,   16'd0};
        tv[7] = '{16'd0,   16'd0};
        tv[8] = '{16'd0,   16'd65436};

        #1;
        chk("rst_out_valid", Out_Valid, 0);
        chk("rst_out_data", Out_Data, 0);
        chk("rst_primed", Primed, 0);
        chk("rst_in_ready", In_Ready, 0);
        repeat (2) @(posedge Clk);
        #1;
        rst = 1'b0;
        chk("latch_in_ready", In_Ready, 0);

        // Vector table, D=4
        for (int i = 0; i < 9; i++) begin
            send(tv[i].x, tv[i].exp);
            chk("t1_primed", Primed, (i >= 3) ? 1 : 0);
        end
        drain();

        // Forward reverb chained into the inverse must give back x
        do_flush(10'd4);
        for (int n = 0; n < 200; n++) begin
            x = DW'($urandom);
            if (n == 50) x = 16'hFFFF;
            if (n == 54) x = 16'h0000;
            y = x + ((n >= 4) ? (yh[n-4] >> 1) : 16'd0);
            yh.push_back(y);
            void'(model(y));
            send(y, x);
        end
        drain();

        // Downstream stall for 5 cycles
        sendm(16'd11);
        Out_Ready = 1'b0;
        held = Out_Data;
        In_Valid = 1'b1;
        In_Data  = 16'd22;
        repeat (5) begin
            @(negedge Clk);
            chk("stall_in_ready", In_Ready, 0);
            chk("stall_hold", Out_Data, held);
            chk("stall_valid", Out_Valid, 1);
        end
        @(posedge Clk);
        #1;
        Out_Ready = 1'b1;
        sendm(16'd22);
        sendm(16'd33);
        drain();

        // Delay 0: passthrough with one cycle latency
        do_flush(10'd0);
        for (int i = 0; i < 6; i++) begin
            x = DW'($urandom);
            sendm(x);
            chk("bypass_valid", Out_Valid, 1);
            chk("bypass_data", Out_Data, x);
            chk("bypass_primed", Primed, 0);
        end
        drain();

        // Flush with a sample offered in RUN, delay 4 -> 7
        do_flush(10'd4);
        for (int i = 0; i < 6; i++) sendm(DW'($urandom));
        drain();
        chk("run_primed", Primed, 1);
        In_Valid  = 1'b1;
        In_Data   = 16'h1234;
        Delay_Num = 10'd7;
        Flush     = 1'b1;
        @(posedge Clk);
        #1;
        Flush    = 1'b0;
        In_Valid = 1'b0;
        hist.delete();
        dlat = 7;
        chk("flush_out_valid", Out_Valid, 0);
        chk("flush_primed", Primed, 0);
        chk("flush_in_ready", In_Ready, 0);
        for (int i = 0; i < 10; i++) begin
            sendm(DW'($urandom));
            chk("t5_primed", Primed, (i >= 6) ? 1 : 0);
        end
        drain();

        // Maximum delay with a long ramp
        do_flush(10'd1023);
        for (int n = 0; n < 3000; n++) begin
            sendm(DW'(n));
            if (n == 1021) chk("max_primed_lo", Primed, 0);
            if (n == 1022) chk("max_primed_hi", Primed, 1);
        end
        drain();

        // Async reset with an output pending
        do_flush(10'd4);
        for (int i = 0; i < 5; i++) sendm(DW'($urandom));
        drain();
        Out_Ready = 1'b0;
        sendm(16'd77);
        chk("pre_rst_valid", Out_Valid, 1);
        chk("pre_rst_primed", Primed, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", Out_Valid, 0);
        chk("arst_out_data", Out_Data, 0);
        chk("arst_primed", Primed, 0);
        chk("arst_in_ready", In_Ready, 0);
        sb.delete();
        hist.delete();
        Delay_Num = 10'd4;
        dlat = 4;
        @(posedge Clk);
        #1;
        rst = 1'b0;
        Out_Ready = 1'b1;
        for (int i = 0; i < 8; i++) sendm(DW'($urandom));
        drain();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
